// File: rtl/rca8_sync_pkg.sv
// -----------------------------------------------------------------------------
// rca8_sync_pkg
// Shared constants for the registered ripple-carry adder slice.
// Holds only the default operand width so that the top and any wrapper agree
// on it without repeating the literal.
// -----------------------------------------------------------------------------
package rca8_sync_pkg;

    localparam int RCA_DEFAULT_WIDTH = 8;

endpackage : rca8_sync_pkg

// File: rtl/rca8_sync_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell, purely combinational. The cells are chained to form
// the ripple-carry core of rca8_sync.
//
// Ports:
//   a  - operand bit A
//   b  - operand bit B
//   ci - carry in
//   s  - sum bit (a ^ b ^ ci)
//   co - carry out (majority of a, b, ci)
// -----------------------------------------------------------------------------
module full_adder
    import rca8_sync_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder

// File: rtl/rca8_sync.sv
// -----------------------------------------------------------------------------
// rca8_sync
// WIDTH-bit ripple-carry adder with a one-cycle registered result:
// {cout, s} = a + b + cin, plus two's-complement overflow and a valid flag.
// The result registers only load when in_valid is high, so idle cycles do not
// toggle the datapath outputs.
//
// Ports:
//   clk       - clock, rising edge active
//   rst_n     - synchronous reset, active low
//   in_valid  - a/b/cin carry a valid operation this cycle
//   a, b      - operands, WIDTH bits
//   cin       - carry into bit 0
//   s         - registered sum, WIDTH bits
//   cout      - registered carry out of the MSB
//   ovf       - registered signed overflow (carry into MSB ^ carry out of MSB)
//   out_valid - s/cout/ovf hold a result from a valid input
// -----------------------------------------------------------------------------
module rca8_sync
    import rca8_sync_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    // Carry chain: carry[i] is the carry into bit i, carry[WIDTH] leaves the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_w;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum_w[i]),
            .co (carry[i+1])
        );
    end

    logic [WIDTH-1:0] s_d,         s_q;
    logic             cout_d,      cout_q;
    logic             ovf_d,       ovf_q;
    logic             out_valid_d, out_valid_q;

    always_comb begin
        // NOTE: every output of this block gets a default first (hold the
        // current value) so no path leaves it unassigned and no latch is inferred.
        s_d         = s_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            s_d    = sum_w;
            cout_d = carry[WIDTH];
            ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule : rca8_sync

// File: tb/tb_rca8_sync.sv
// -----------------------------------------------------------------------------
// tb_rca8_sync
// Self-checking bench for rca8_sync (WIDTH = 8). A behavioural model computes
// the expected registered outputs from plain integer arithmetic; a compare
// process checks the DUT against it on every falling edge once reset has been
// applied. Directed vectors add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_rca8_sync;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout, ovf, out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    rca8_sync #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       model_init = 1'b0;
    int       m_s, m_cout, m_ovf, m_valid;

    always @(posedge clk) begin
        int total, sa, sb, ssum;
        if (rst_n === 1'b0) begin
            m_s = 0; m_cout = 0; m_ovf = 0; m_valid = 0;
            model_init = 1'b1;
        end else if (in_valid === 1'b1) begin
            total   = int'(a) + int'(b) + int'(cin);
            m_s     = total % 256;
            m_cout  = total / 256;
            // Signed view: overflow when the true signed sum leaves [-128,127].
            sa      = (a >= 8'd128) ? int'(a) - 256 : int'(a);
            sb      = (b >= 8'd128) ? int'(b) - 256 : int'(b);
            ssum    = sa + sb + int'(cin);
            m_ovf   = (ssum > 127 || ssum < -128) ? 1 : 0;
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (model_init) begin
            check("model_cmp", {20'd0, out_valid, ovf, cout, 1'b0, s},
                  {20'd0, m_valid[0], m_ovf[0], m_cout[0], 1'b0, m_s[7:0]});
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle of inputs, then advance just past the capturing edge.
    task automatic drive(input logic v, input logic [7:0] va, input logic [7:0] vb, input logic vc);
        in_valid = v; a = va; b = vb; cin = vc;
        @(posedge clk); #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] es, input logic ec,
                              input logic eo, input logic ev);
        check({name, "_s"},    32'(s),         32'(es));
        check({name, "_cout"}, 32'(cout),      32'(ec));
        check({name, "_ovf"},  32'(ovf),       32'(eo));
        check({name, "_vld"},  32'(out_valid), 32'(ev));
    endtask

    logic [7:0] b_set [16] = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h33, 8'h55, 8'h7E,
                               8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hFE, 8'hFF};

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        drive(1'b1, 8'hFF, 8'hFF, 1'b0); expect_out("max_c0",   8'hFE, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'hFF, 8'hFF, 1'b1); expect_out("max_c1",   8'hFF, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'hFF, 8'h00, 1'b1); expect_out("ripple",   8'h00, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'h00, 8'h00, 1'b0); expect_out("zero",     8'h00, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h7F, 8'h01, 1'b0); expect_out("ovf_pos",  8'h80, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 8'h80, 8'h80, 1'b0); expect_out("ovf_neg",  8'h00, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 8'd3,  8'd4,  1'b0); expect_out("hold_a",   8'd7,  1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'd9,  8'd9,  1'b0); expect_out("hold_b",   8'd7,  1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'd1,  8'd1,  1'b0); expect_out("b2b_1",    8'd2,  1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'd2,  8'd2,  1'b0); expect_out("b2b_2",    8'd4,  1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'd3,  8'd3,  1'b0); expect_out("b2b_3",    8'd6,  1'b0, 1'b0, 1'b1);

        // Sweep every a and cin against a spread of b values; the compare
        // process checks each result against the model.
        for (int bi = 0; bi < 16; bi++) begin
            for (int ai = 0; ai < 256; ai++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    drive(1'b1, 8'(ai), b_set[bi], 1'(ci));
                end
            end
            if (bi == 7) begin
                // Mid-stream reset with a valid operation pending: it must be discarded.
                rst_n = 1'b0;
                drive(1'b1, 8'h55, 8'h22, 1'b1);
                expect_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
                rst_n = 1'b1;
            end
        end

        drive(1'b0, 8'h00, 8'h00, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rca8_sync
